// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and counter-width helper for the shift-add multiplier sequencer
package mult_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} mult_state_t;
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: handshake and strobe bundle between the sequencer and the product register
//   start, Q0 (, abort)                    : requests and multiplier LSB into the sequencer
//   reg_reset, add_shift, shift, busy, done : strobes and status out of the sequencer
//   abort only exists when MULT_SEQ_ABORT_EN is defined
interface mult_sequencer_if;
    logic start;
    logic Q0;
    logic reg_reset;
    logic add_shift;
    logic shift;
    logic busy;
    logic done;
`ifdef MULT_SEQ_ABORT_EN
    logic abort;
    modport master (input start, Q0, abort, output reg_reset, add_shift, shift, busy, done);
    modport slave (output start, Q0, abort, input reg_reset, add_shift, shift, busy, done);
`else
    modport master (input start, Q0, output reg_reset, add_shift, shift, busy, done);
    modport slave (output start, Q0, input reg_reset, add_shift, shift, busy, done);
`endif
endinterface

// File: rtl/mult_sequencer_step_counter.sv
// step_counter: loadable down-counter with zero flag
//   clock, reset_n : clock and asynchronous active-low reset
//   load, value    : load value into cnt (load wins over dec)
//   dec            : decrement cnt by one
//   cnt, zero      : current count and cnt==0 flag
module step_counter #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic [W-1:0] cnt,
    output logic         zero
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (dec) cnt <= cnt - W'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: IDLE/LOAD/RUN/DONE controller driving the shift-add product register
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (master)   : start, Q0 in; reg_reset, add_shift, shift, busy, done out
//   MULT_SEQ_ABORT_EN adds bus.abort, which cancels LOAD/RUN back to IDLE without done
module mult_sequencer import mult_pkg::*; #(
    parameter int n = 8
) (
    input logic              clock,
    input logic              reset_n,
    mult_sequencer_if.master bus
);
    localparam int W = cnt_width(n);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;
    logic [1:0]   state, state_nxt;
    logic [W-1:0] cnt;
    logic         zero, in_load, in_run, kill;
    assign in_load = state == ST_LOAD;
    assign in_run  = state == ST_RUN;
`ifdef MULT_SEQ_ABORT_EN
    assign kill = bus.abort & (in_load | in_run);
`else
    assign kill = 1'b0;
`endif
    step_counter #(.W(W)) u_cnt (
        .clock(clock), .reset_n(reset_n), .load(in_load), .dec(in_run),
        .value(W'(n - 1)), .cnt(cnt), .zero(zero)
    );
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = bus.start ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_nxt = kill ? ST_IDLE : ST_RUN;
            ST_RUN:  state_nxt = kill ? ST_IDLE : (zero ? ST_DONE : ST_RUN);
            default: state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= ST_IDLE;
        else state <= state_nxt;
    // RUN strobes are Mealy on the register's LSB; abort blanks them in its cycle
    assign bus.reg_reset = in_load & ~kill;
    assign bus.add_shift = in_run & bus.Q0 & ~kill;
    assign bus.shift     = in_run & ~bus.Q0 & ~kill;
    assign bus.busy      = in_load | in_run;
    assign bus.done      = state == ST_DONE;
endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Control sequencer for the shift-add multiplier datapath. It sits directly upstream of the `register` block (the A/Q/C product register) and produces that block's `reset`, `add_shift` and `shift` strobes. On a `start` request it loads the operands, then runs `n` add-or-shift steps chosen by the current multiplier LSB. It finishes by signalling completion, at which point the register's `AQ` output holds the 2n-bit product.

## Interface
Parameters:
- `n`, default 8, operand width; the sequencer runs exactly `n` steps, and `n` must be ≥ 2.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  request a multiplication; sampled only in IDLE.
- `Q0`  in  1  current `AQ[0]`, the multiplier LSB, taken from the product register.
- `reg_reset`  out  1  drives the product register `reset`: clears A and C, loads Q from `Qin`.
- `add_shift`  out  1  drives the register `add_shift`: AQ <= {C,Sum,Q} >> 1.
- `shift`  out  1  drives the register `shift`: AQ <= AQ >> 1.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  one-cycle pulse; product valid on `AQ` in this cycle.
- `abort`  in  1  only present with `MULT_SEQ_ABORT_EN` (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, DONE. A step counter `cnt` is $clog2(n) bits wide.
- IDLE: all outputs 0. `start`=1 → LOAD; otherwise stay in IDLE.
- LOAD: `reg_reset`=1 and `busy`=1. Loads `cnt` <= n-1. Always goes to RUN.
- RUN: `busy`=1.
  - `add_shift` = `Q0` and `shift` = ~`Q0` (Mealy outputs from the registered `Q0`); exactly one of the two is high in each RUN cycle.
  - `cnt` decrements each cycle. At `cnt`==0 → DONE.
- DONE: `done`=1, `busy`=0, no strobes. Always goes to IDLE; `start` is ignored in this state.
- `start` is ignored in LOAD, RUN and DONE, so a new request needs `start` held or reasserted in IDLE.
- Output uniqueness: `reg_reset`, `add_shift` and `shift` are mutually exclusive in every cycle.

## Timing
- Reset values: state IDLE, `cnt`=0, `reg_reset`=`add_shift`=`shift`=`busy`=`done`=0.
- Reset is asynchronous: asserting `reset_n` low at any point, including mid-RUN, forces IDLE and zeros all outputs immediately. The register contents are then undefined until the next LOAD.
- Cycle sequence, where T is the rising edge that samples `start`=1 in IDLE:
  - LOAD occupies T..T+1.
  - RUN occupies T+1..T+n+1 (n cycles).
  - DONE occupies T+n+1..T+n+2.
- Latency from `start` sample to `done` is n+1 cycles. The minimum start-to-start period is n+3 cycles.
- `Q0` must be settled before each RUN edge. The register updates `AQ` on the same edge, so the next step sees the new LSB.

## Configuration
- `MULT_SEQ_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 sampled in LOAD or RUN → IDLE on the next edge, with no `done` pulse. In that cycle the strobes are forced to 0.
  - `abort` has no effect in IDLE or DONE.
- Not defined: no `abort` port and no abort logic.

## Structure
- Shared package `mult_pkg`:
  - `mult_state_t` enum {IDLE, LOAD, RUN, DONE}.
  - Function `cnt_width(n)` = $clog2(n).
- One sub-module, `step_counter`: a parameterised down-counter with load, decrement and `zero` flag, instantiated for `cnt`.
- The FSM and output decode live in `mult_sequencer`.

## Test plan
Bench setup: n=8, with `mult_sequencer` driving a real `register` instance that has `Qin`=0xE5, and `Sum` from an adder of A+0x47.
- Reset and idle: hold `reset_n`=0, then release → all outputs 0. No strobes while `start`=0 for 20 cycles.
- Normal run, `start` for 1 cycle:
  - `reg_reset` for 1 cycle, then the RUN strobes in order add,shift,add,shift,shift,add,add,add (the LSBs of 0xE5).
  - `done` 9 cycles after the `start` sample, with `AQ`=0x47×0xE5=0x3F83.
- `start` held high throughout → back-to-back operations with period 11 cycles. `start` during RUN/DONE causes no extra LOAD.
- Operand edges:
  - `Qin`=0x00 → 8 `shift` strobes only, product 0.
  - `Qin`=0xFF with `Sum` from 0xFF → 8 `add_shift` strobes, product 0xFE01.
- Reset mid-operation: drive `reset_n` low during the 4th RUN cycle → outputs 0 immediately, state IDLE. A subsequent `start` yields a correct product.
- Abort (`MULT_SEQ_ABORT_EN` only): `abort` in the 3rd RUN cycle → IDLE next edge, no `done`, strobes 0 in that cycle.
